// File: rtl/queue_dispatcher_if.sv
// Handshake bundle between the arbiter/input FIFOs, the dispatcher and the downstream consumer.
// The slave modport is the dispatcher's view; the master modport is the surrounding environment's view.
interface queue_dispatcher_if #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int DATA_BITS      = 8,
   parameter int SEL_BITS       = 2
);
   logic [SEL_BITS-1:0]                 selector;
   logic                                out_enb;
   logic [QUEUE_QUANTITY-1:0]           buf_empty;
   logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data;
   logic [QUEUE_QUANTITY-1:0]           pop;
   logic [DATA_BITS-1:0]                data_out;
   logic [SEL_BITS-1:0]                 src_out;
   logic                                valid_out;
   logic                                ready_in;
   logic                                stall;
   logic                                err_empty;

   modport slave (
      input  selector, out_enb, buf_empty, fifo_data, ready_in,
      output pop, data_out, src_out, valid_out, stall, err_empty
   );

   modport master (
      output selector, out_enb, buf_empty, fifo_data, ready_in,
      input  pop, data_out, src_out, valid_out, stall, err_empty
   );
endinterface

// File: rtl/queue_dispatcher.sv
// Converts arbiter grants into FIFO pops, captures the returned word one cycle later and
// presents it, tagged with its source queue, on a valid/ready port backed by a 2-entry buffer.
module queue_dispatcher #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int DATA_BITS      = 8,
   parameter int SEL_BITS       = 2
) (
   input logic                clk,
   input logic                rst,
   input logic                enb,
   queue_dispatcher_if.slave  bus
);

   logic                 inflight;
   logic [SEL_BITS-1:0]  tag;
   logic [DATA_BITS-1:0] head_data;
   logic [SEL_BITS-1:0]  head_src;
   logic [DATA_BITS-1:0] tail_data;
   logic [SEL_BITS-1:0]  tail_src;
   logic [1:0]           buf_count;

   logic                 drain;
   logic [1:0]           occ;
   logic [1:0]           occ_after;
   logic                 room;
   logic                 grant;
   logic                 issue;
   logic                 empty_hit;
   logic [DATA_BITS-1:0] wr_data;

   assign drain     = (buf_count != 2'd0) && bus.ready_in;
   assign occ       = buf_count + {1'b0, inflight};
   assign occ_after = occ - {1'b0, drain};
   // Room counts the word already in flight, so it always has a slot when it lands.
   assign room      = (occ_after < 2'd2);
   assign grant     = rst && enb && bus.out_enb;
   assign issue     = grant && !bus.buf_empty[bus.selector] && room;
   assign empty_hit = grant && bus.buf_empty[bus.selector] && room;
   assign wr_data   = bus.fifo_data[int'(tag)*DATA_BITS +: DATA_BITS];

   always_comb begin
      bus.pop = '0;
      if (issue) begin
         bus.pop[bus.selector] = 1'b1;
      end
   end

   assign bus.stall     = !room;
   assign bus.valid_out = (buf_count != 2'd0);
   assign bus.data_out  = head_data;
   assign bus.src_out   = head_src;

   // Head/tail shift buffer: the head always drives the output port, so the output
   // order is the pop order and a write can coincide with a drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight  <= 1'b0;
         tag       <= '0;
         head_data <= '0;
         head_src  <= '0;
         tail_data <= '0;
         tail_src  <= '0;
         buf_count <= 2'd0;
         bus.err_empty <= 1'b0;
      end else begin
         inflight      <= issue;
         bus.err_empty <= empty_hit;
         if (issue) begin
            tag <= bus.selector;
         end
         case ({inflight, drain})
            2'b10: begin
               if (buf_count == 2'd0) begin
                  head_data <= wr_data;
                  head_src  <= tag;
               end else begin
                  tail_data <= wr_data;
                  tail_src  <= tag;
               end
               buf_count <= buf_count + 2'd1;
            end
            2'b01: begin
               head_data <= tail_data;
               head_src  <= tail_src;
               buf_count <= buf_count - 2'd1;
            end
            2'b11: begin
               if (buf_count == 2'd1) begin
                  head_data <= wr_data;
                  head_src  <= tag;
               end else begin
                  head_data <= tail_data;
                  head_src  <= tail_src;
                  tail_data <= wr_data;
                  tail_src  <= tag;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed bench for queue_dispatcher: streaming, backpressure, empty grants, enable gating,
// mid-flight reset and simultaneous drain/pop, each with hand-computed expectations.
module tb_queue_dispatcher;

   logic clk;
   logic rst;
   logic enb;
   int   checks;
   int   passed;

   queue_dispatcher_if #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .SEL_BITS(2)) bus ();

   queue_dispatcher #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .SEL_BITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .enb (enb),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer occupancy must never exceed two words.
   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (dut.buf_count > 2'd2) $display("[TB] FAIL overflow: buf_count=%0d required<=2", dut.buf_count);
         else passed++;
      end
   end

   task automatic drive(input logic e, input logic oe, input logic [1:0] s,
                        input logic [3:0] be, input logic r);
      @(negedge clk);
      enb           = e;
      bus.out_enb   = oe;
      bus.selector  = s;
      bus.buf_empty = be;
      bus.ready_in  = r;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      enb = 1'b1;
      bus.out_enb   = 1'b0;
      bus.selector  = 2'd0;
      bus.buf_empty = 4'h0;
      bus.ready_in  = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      enb = 1'b1;
      bus.out_enb   = 1'b1;
      bus.selector  = 2'd2;
      bus.buf_empty = 4'h0;
      bus.ready_in  = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (bus.pop !== 4'h0) $display("[TB] FAIL reset_pop: got %b want 0000", bus.pop); else passed++;
      checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", bus.valid_out); else passed++;
      checks++; if (bus.data_out !== 8'h00) $display("[TB] FAIL reset_data: got %h want 00", bus.data_out); else passed++;
      checks++; if (bus.src_out !== 2'd0) $display("[TB] FAIL reset_src: got %0d want 0", bus.src_out); else passed++;
      checks++; if (bus.err_empty !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", bus.err_empty); else passed++;
      checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", bus.stall); else passed++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (bus.pop !== 4'b0100) $display("[TB] FAIL release_pop: got %b want 0100", bus.pop); else passed++;
   endtask

   task automatic test_streaming();
      logic [3:0] ep [7];
      logic       ev [7];
      logic [7:0] ed [7];
      ep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
      ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ed = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive(1'b1, c < 4, 2'(c), 4'h0, 1'b1);
         checks++; if (bus.pop !== ep[c]) $display("[TB] FAIL stream_pop c%0d: got %b want %b", c, bus.pop, ep[c]); else passed++;
         checks++; if (bus.valid_out !== ev[c]) $display("[TB] FAIL stream_valid c%0d: got %b want %b", c, bus.valid_out, ev[c]); else passed++;
         checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL stream_stall c%0d: got %b want 0", c, bus.stall); else passed++;
         if (ev[c]) begin
            checks++; if (bus.data_out !== ed[c]) $display("[TB] FAIL stream_data c%0d: got %h want %h", c, bus.data_out, ed[c]); else passed++;
            checks++; if (bus.src_out !== 2'(c - 2)) $display("[TB] FAIL stream_src c%0d: got %0d want %0d", c, bus.src_out, c - 2); else passed++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] sel [9];
      logic [3:0] ep  [9];
      logic       es  [9];
      logic       ev  [9];
      logic [7:0] ed  [9];
      logic [1:0] esr [9];
      sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};
      ep  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
      es  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ev  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ed  = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h00};
      esr = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
      do_reset();
      for (int c = 0; c < 9; c++) begin
         drive(1'b1, c <= 5, sel[c], 4'h0, c >= 5);
         checks++; if (bus.pop !== ep[c]) $display("[TB] FAIL bp_pop c%0d: got %b want %b", c, bus.pop, ep[c]); else passed++;
         checks++; if (bus.stall !== es[c]) $display("[TB] FAIL bp_stall c%0d: got %b want %b", c, bus.stall, es[c]); else passed++;
         checks++; if (bus.valid_out !== ev[c]) $display("[TB] FAIL bp_valid c%0d: got %b want %b", c, bus.valid_out, ev[c]); else passed++;
         if (ev[c]) begin
            checks++; if (bus.data_out !== ed[c]) $display("[TB] FAIL bp_data c%0d: got %h want %h", c, bus.data_out, ed[c]); else passed++;
            checks++; if (bus.src_out !== esr[c]) $display("[TB] FAIL bp_src c%0d: got %0d want %0d", c, bus.src_out, esr[c]); else passed++;
         end
      end
   endtask

   task automatic test_empty_grant();
      logic       oe [6];
      logic [3:0] ep [6];
      logic       ee [6];
      logic       ev [6];
      oe = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      ep = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      ee = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, oe[c], 2'd0, (c < 3) ? 4'b0001 : 4'b0000, 1'b1);
         checks++; if (bus.pop !== ep[c]) $display("[TB] FAIL empty_pop c%0d: got %b want %b", c, bus.pop, ep[c]); else passed++;
         checks++; if (bus.err_empty !== ee[c]) $display("[TB] FAIL empty_err c%0d: got %b want %b", c, bus.err_empty, ee[c]); else passed++;
         checks++; if (bus.valid_out !== ev[c]) $display("[TB] FAIL empty_valid c%0d: got %b want %b", c, bus.valid_out, ev[c]); else passed++;
      end
      checks++; if (bus.data_out !== 8'h11) $display("[TB] FAIL empty_data: got %h want 11", bus.data_out); else passed++;
   endtask

   task automatic test_enable_gating();
      logic [3:0] ep [6];
      logic       ev [6];
      logic [7:0] ed [6];
      logic [1:0] es [6];
      ep = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ed = '{8'h00, 8'h00, 8'h22, 8'h22, 8'h44, 8'h00};
      es = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(c < 2, 1'b1, (c == 0) ? 2'd1 : ((c == 1) ? 2'd3 : 2'd0),
               (c < 2) ? 4'h0 : 4'hF, c >= 3);
         checks++; if (bus.pop !== ep[c]) $display("[TB] FAIL enb_pop c%0d: got %b want %b", c, bus.pop, ep[c]); else passed++;
         checks++; if (bus.err_empty !== 1'b0) $display("[TB] FAIL enb_err c%0d: got %b want 0", c, bus.err_empty); else passed++;
         checks++; if (bus.valid_out !== ev[c]) $display("[TB] FAIL enb_valid c%0d: got %b want %b", c, bus.valid_out, ev[c]); else passed++;
         if (ev[c]) begin
            checks++; if (bus.data_out !== ed[c]) $display("[TB] FAIL enb_data c%0d: got %h want %h", c, bus.data_out, ed[c]); else passed++;
            checks++; if (bus.src_out !== es[c]) $display("[TB] FAIL enb_src c%0d: got %0d want %0d", c, bus.src_out, es[c]); else passed++;
         end
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      drive(1'b1, 1'b1, 2'd0, 4'h0, 1'b0);
      drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
      drive(1'b1, 1'b1, 2'd2, 4'h0, 1'b0);
      checks++; if (bus.pop !== 4'b0100) $display("[TB] FAIL mid_pop: got %b want 0100", bus.pop); else passed++;
      checks++; if (bus.data_out !== 8'h11) $display("[TB] FAIL mid_data: got %h want 11", bus.data_out); else passed++;
      @(negedge clk);
      rst = 1'b0;
      bus.selector = 2'd3;
      #1;
      checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %b want 0", bus.valid_out); else passed++;
      checks++; if (bus.pop !== 4'b0000) $display("[TB] FAIL mid_rst_pop: got %b want 0000", bus.pop); else passed++;
      checks++; if (bus.data_out !== 8'h00) $display("[TB] FAIL mid_rst_data: got %h want 00", bus.data_out); else passed++;
      @(negedge clk);
      rst = 1'b1;
      bus.out_enb = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
         checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL mid_after_valid c%0d: got %b want 0", c, bus.valid_out); else passed++;
      end
      drive(1'b1, 1'b1, 2'd3, 4'h0, 1'b1);
      checks++; if (bus.pop !== 4'b1000) $display("[TB] FAIL mid_fresh_pop: got %b want 1000", bus.pop); else passed++;
      drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
      checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL mid_fresh_lat: got %b want 0", bus.valid_out); else passed++;
      drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
      checks++; if (bus.valid_out !== 1'b1) $display("[TB] FAIL mid_fresh_valid: got %b want 1", bus.valid_out); else passed++;
      checks++; if (bus.data_out !== 8'h44) $display("[TB] FAIL mid_fresh_data: got %h want 44", bus.data_out); else passed++;
      checks++; if (bus.src_out !== 2'd3) $display("[TB] FAIL mid_fresh_src: got %0d want 3", bus.src_out); else passed++;
   endtask

   task automatic test_back_to_back();
      logic       oe  [9];
      logic [1:0] sel [9];
      logic [3:0] ep  [9];
      logic       es  [9];
      logic       ev  [9];
      logic [7:0] ed  [9];
      oe  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      sel = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
      ep  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
      es  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ev  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ed  = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      do_reset();
      for (int c = 0; c < 9; c++) begin
         drive(1'b1, oe[c], sel[c], 4'h0, c >= 4);
         checks++; if (bus.pop !== ep[c]) $display("[TB] FAIL b2b_pop c%0d: got %b want %b", c, bus.pop, ep[c]); else passed++;
         checks++; if (bus.stall !== es[c]) $display("[TB] FAIL b2b_stall c%0d: got %b want %b", c, bus.stall, es[c]); else passed++;
         checks++; if (bus.valid_out !== ev[c]) $display("[TB] FAIL b2b_valid c%0d: got %b want %b", c, bus.valid_out, ev[c]); else passed++;
         if (ev[c]) begin
            checks++; if (bus.data_out !== ed[c]) $display("[TB] FAIL b2b_data c%0d: got %h want %h", c, bus.data_out, ed[c]); else passed++;
         end
         if (c == 3 || c == 4) begin
            checks++; if (dut.buf_count !== 2'd2) $display("[TB] FAIL b2b_full c%0d: got %0d want 2", c, dut.buf_count); else passed++;
         end
      end
   endtask

   initial begin
      checks = 0;
      passed = 0;
      bus.fifo_data = {8'h44, 8'h33, 8'h22, 8'h11};
      test_reset();
      test_streaming();
      test_backpressure();
      test_empty_grant();
      test_enable_gating();
      test_reset_midflight();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
